gasket_rx_ctrl: RTL and testbench
=================================

GASKET_RX_CTRL -- requirements
Module: gasket_rx_ctrl

Interface
REQ-001 Parameter COM_SYM, default 8'hBC: alignment K-symbol value.
REQ-002 Parameter LOCK_CNT, default 4: consecutive aligned COMs required to lock.
REQ-003 Parameter UNLOCK_CNT, default 3: misaligned COMs in LOCKED that drop lock.
REQ-004 Parameter WIDTH_RST, default 6'd16: width applied out of reset.
REQ-005 One clock and one reset: PCLK in 1, symbol clock, one symbol per rising edge; Rst_n in 1, asynchronous, active-low.
REQ-006 Data_in in 8: received decoded symbol.
REQ-007 Rx_Datak in 1: Data_in is a K-symbol.
REQ-008 Req_width in 6: requested gasket width, legal 8/16/32.
REQ-009 Req_valid in 1 and Req_ready out 1: width-request handshake; transfer occurs when both are high on a PCLK edge.
REQ-010 Width out 6: width currently applied to the gasket datapath.
REQ-011 Lane_idx out 2: byte lane of the current symbol within its group.
REQ-012 Group_done out 1: current symbol is the last of its group.
REQ-013 Rx_valid out 1: alignment locked and gasket data valid.
REQ-014 Align_err out 1: one-cycle pulse on a misaligned COM while LOCKED.
REQ-015 Cfg_err out 1: one-cycle pulse on acceptance of an illegal Req_width.

Function
REQ-016 Group size N SHALL be 1, 2 or 4 for Width 8, 16 or 32.
REQ-017 Lane_idx SHALL advance by 1 each cycle and wrap from N-1 to 0.
REQ-018 Group_done SHALL be combinational (Lane_idx == N-1).
REQ-019 COM is Rx_Datak=1 and Data_in=COM_SYM; it is aligned if Lane_idx=0, otherwise misaligned.
REQ-020 Realign SHALL treat the current COM as lane 0, setting the next Lane_idx to 1 mod N.
REQ-021 FSM states SHALL be HUNT, CONFIRM, LOCKED and SWITCH, with HUNT as the reset state.
REQ-022 HUNT: any COM SHALL realign, set good_cnt=1 and go to CONFIRM; non-COM symbols SHALL be ignored.
REQ-023 CONFIRM: an aligned COM SHALL increment good_cnt, and reaching LOCK_CNT SHALL go to LOCKED; a misaligned COM SHALL realign and set good_cnt=1.
REQ-024 LOCKED: Rx_valid=1; a misaligned COM SHALL increment bad_cnt and pulse Align_err without realigning; an aligned COM SHALL clear bad_cnt.
REQ-025 LOCKED: bad_cnt reaching UNLOCK_CNT SHALL realign, drop Rx_valid next cycle and go to CONFIRM with good_cnt=1.
REQ-026 Rx_valid SHALL rise on the edge after the LOCK_CNT-th aligned COM (1-cycle latency).
REQ-027 Req_ready SHALL be 1 in HUNT, CONFIRM and LOCKED, and 0 in SWITCH and during reset.
REQ-028 Accepted illegal width: Cfg_err pulse next cycle; no state or Width change.
REQ-029 Accepted width equal to Width: no-op.
REQ-030 Accepted legal different width: latch pend_width, enter SWITCH, clear Rx_valid next cycle.
REQ-031 SWITCH: on the cycle with Group_done=1, Width<=pend_width, Lane_idx<=0, good_cnt and bad_cnt<=0, go to HUNT.
REQ-032 SWITCH: COMs SHALL be ignored for alignment and error counting.
REQ-033 Simultaneous width acceptance and COM in the same cycle: the acceptance wins; the COM is ignored.
REQ-034 Counters SHALL saturate and never wrap.

Reset
REQ-035 Rst_n low SHALL asynchronously set state=HUNT, Width=WIDTH_RST, Lane_idx=0, Rx_valid=0, Align_err=0, Cfg_err=0, Req_ready=0, counters=0 and pend_width=WIDTH_RST.
REQ-036 Reset asserted mid-SWITCH SHALL discard pend_width.
REQ-037 All outputs except Group_done SHALL be registered.

Structure
REQ-038 A shared package SHALL hold the width encodings (8/16/32), the FSM state encoding and the default COM_SYM.
REQ-039 One sub-module, gasket_lane_cnt, SHALL hold the Lane_idx counter with load/realign inputs and the Group_done decode.

Verification
REQ-040 After reset, COMs at Lane_idx 0 with period 4 at Width 16 -> Rx_valid=1 one cycle after the 4th COM.
REQ-041 Locked at Width 16, three COMs at Lane_idx 1 -> three Align_err pulses; Rx_valid=0 after the 3rd; Lane_idx=0 on the next cycle.
REQ-042 Locked at Width 16, Req_width=32 accepted at Lane_idx 0 -> Req_ready=0; Width=32 after the Group_done cycle; state HUNT; Rx_valid=0.
REQ-043 Req_width=12 accepted -> Cfg_err pulse; Width unchanged; Rx_valid unchanged.
REQ-044 COM arriving in the same cycle as a width acceptance -> no good_cnt change; SWITCH entered.
REQ-045 Rst_n asserted mid-SWITCH -> Width=16, HUNT, Req_ready=0 until release.

Source files
------------

// File: rtl/gasket_pkg.sv
// Shared encodings for the gasket receive controller.
// Width codes, FSM states and small helpers.
package gasket_pkg;

  localparam logic [5:0] W8  = 6'd8;
  localparam logic [5:0] W16 = 6'd16;
  localparam logic [5:0] W32 = 6'd32;

  localparam logic [7:0] COM_SYM_DEF = 8'hBC;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2,
    SWITCH  = 2'd3
  } state_e;

  function automatic logic [1:0] last_lane(input logic [5:0] w);
    logic [1:0] r;
    r = 2'd1;
    unique case (1'b1)
      (w == W8):  r = 2'd0;
      (w == W32): r = 2'd3;
      default:    r = 2'd1;
    endcase
    return r;
  endfunction

  function automatic logic legal_w(input logic [5:0] w);
    return (w == W8) || (w == W16) || (w == W32);
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/gasket_lane_cnt.sv
// Byte-lane counter within a gasket group.
// Supports a zero load and a COM-driven realign.
module gasket_lane_cnt
  import gasket_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [5:0] width_i,
  input  logic       load_i,
  input  logic       realign_i,
  output logic [1:0] lane_idx_o,
  output logic       group_done_o
);

  logic [1:0] lane_q;
  logic [1:0] lane_d;
  logic [1:0] last;

  assign last = last_lane(width_i);

  always_comb begin
    lane_d = lane_q + 2'd1;
    if (lane_q >= last)
      lane_d = 2'd0;
    if (realign_i)
      lane_d = (last == 2'd0) ? 2'd0 : 2'd1;
    if (load_i)
      lane_d = 2'd0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      lane_q <= 2'd0;
    else
      lane_q <= lane_d;
  end

  assign lane_idx_o   = lane_q;
  assign group_done_o = (lane_q == last);

endmodule

// File: rtl/gasket_rx_ctrl.sv
// Receive alignment and width control for the gasket.
// Hunts COMs, locks lanes and switches width on group end.
module gasket_rx_ctrl
  import gasket_pkg::*;
#(
  parameter logic [7:0] COM_SYM    = COM_SYM_DEF,
  parameter int         LOCK_CNT   = 4,
  parameter int         UNLOCK_CNT = 3,
  parameter logic [5:0] WIDTH_RST  = 6'd16
) (
  input  logic       PCLK,
  input  logic       Rst_n,
  input  logic [7:0] Data_in,
  input  logic       Rx_Datak,
  input  logic [5:0] Req_width,
  input  logic       Req_valid,
  output logic       Req_ready,
  output logic [5:0] Width,
  output logic [1:0] Lane_idx,
  output logic       Group_done,
  output logic       Rx_valid,
  output logic       Align_err,
  output logic       Cfg_err
);

  localparam logic [3:0] LOCK_C   = 4'(LOCK_CNT);
  localparam logic [3:0] UNLOCK_C = 4'(UNLOCK_CNT);

  state_e     state_q, state_d;
  logic [5:0] width_q, width_d;
  logic [5:0] pend_q, pend_d;
  logic [3:0] good_q, good_d;
  logic [3:0] bad_q, bad_d;
  logic       rxv_q, rxv_d;
  logic       aerr_q, aerr_d;
  logic       cerr_q, cerr_d;
  logic       rdy_q, rdy_d;
  logic       load, realign;
  logic       com, aligned, acc;
  logic [3:0] good_inc, bad_inc;

  gasket_lane_cnt u_lane (
    .clk_i        (PCLK),
    .rst_ni       (Rst_n),
    .width_i      (width_q),
    .load_i       (load),
    .realign_i    (realign),
    .lane_idx_o   (Lane_idx),
    .group_done_o (Group_done)
  );

  assign com      = Rx_Datak && (Data_in == COM_SYM);
  assign aligned  = (Lane_idx == 2'd0);
  assign acc      = Req_valid && rdy_q;
  assign good_inc = sat_inc(good_q);
  assign bad_inc  = sat_inc(bad_q);

  always_comb begin
    state_d = state_q;
    width_d = width_q;
    pend_d  = pend_q;
    good_d  = good_q;
    bad_d   = bad_q;
    aerr_d  = 1'b0;
    cerr_d  = 1'b0;
    load    = 1'b0;
    realign = 1'b0;
    if (acc && state_q != SWITCH) begin
      // Acceptance shadows any COM seen this cycle
      if (!legal_w(Req_width)) begin
        cerr_d = 1'b1;
      end else if (Req_width != width_q) begin
        pend_d  = Req_width;
        state_d = SWITCH;
      end
    end else begin
      unique case (state_q)
        HUNT: begin
          if (com) begin
            realign = 1'b1;
            good_d  = 4'd1;
            state_d = (LOCK_C <= 4'd1) ? LOCKED : CONFIRM;
          end
        end
        CONFIRM: begin
          if (com && aligned) begin
            good_d = good_inc;
            if (good_inc >= LOCK_C)
              state_d = LOCKED;
          end else if (com) begin
            realign = 1'b1;
            good_d  = 4'd1;
          end
        end
        LOCKED: begin
          if (com && aligned) begin
            bad_d = 4'd0;
          end else if (com) begin
            aerr_d = 1'b1;
            bad_d  = bad_inc;
            if (bad_inc >= UNLOCK_C) begin
              realign = 1'b1;
              good_d  = 4'd1;
              bad_d   = 4'd0;
              state_d = CONFIRM;
            end
          end
        end
        SWITCH: begin
          if (Group_done) begin
            width_d = pend_q;
            load    = 1'b1;
            good_d  = 4'd0;
            bad_d   = 4'd0;
            state_d = HUNT;
          end
        end
      endcase
    end
    rxv_d = (state_d == LOCKED);
    rdy_d = (state_d != SWITCH);
  end

  always_ff @(posedge PCLK or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= HUNT;
      width_q <= WIDTH_RST;
      pend_q  <= WIDTH_RST;
      good_q  <= 4'd0;
      bad_q   <= 4'd0;
      rxv_q   <= 1'b0;
      aerr_q  <= 1'b0;
      cerr_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      width_q <= width_d;
      pend_q  <= pend_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      rxv_q   <= rxv_d;
      aerr_q  <= aerr_d;
      cerr_q  <= cerr_d;
      rdy_q   <= rdy_d;
    end
  end

  assign Width     = width_q;
  assign Rx_valid  = rxv_q;
  assign Align_err = aerr_q;
  assign Cfg_err   = cerr_q;
  assign Req_ready = rdy_q;

endmodule

// File: tb/tb_gasket_rx_ctrl.sv
// Directed bench for gasket_rx_ctrl.
// Lock, unlock, width switch, config error and reset cases.
module tb_gasket_rx_ctrl;

  logic       PCLK = 1'b0;
  logic       Rst_n;
  logic [7:0] Data_in;
  logic       Rx_Datak;
  logic [5:0] Req_width;
  logic       Req_valid;
  logic       Req_ready;
  logic [5:0] Width;
  logic [1:0] Lane_idx;
  logic       Group_done;
  logic       Rx_valid;
  logic       Align_err;
  logic       Cfg_err;

  int nvec = 0;
  int nmis = 0;

  gasket_rx_ctrl dut (
    .PCLK       (PCLK),
    .Rst_n      (Rst_n),
    .Data_in    (Data_in),
    .Rx_Datak   (Rx_Datak),
    .Req_width  (Req_width),
    .Req_valid  (Req_valid),
    .Req_ready  (Req_ready),
    .Width      (Width),
    .Lane_idx   (Lane_idx),
    .Group_done (Group_done),
    .Rx_valid   (Rx_valid),
    .Align_err  (Align_err),
    .Cfg_err    (Cfg_err)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic com(input logic on);
    Rx_Datak = on;
    Data_in  = on ? 8'hBC : 8'h00;
  endtask

  task automatic idle(input int n);
    com(1'b0);
    for (int i = 0; i < n; i++) tick();
  endtask

  // COM at lane 0, then pad so the next call also lands on lane 0
  task automatic com_period();
    com(1'b1);
    tick();
    idle(3);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst_n = 1'b0;
    Req_width = 6'd16;
    Req_valid = 1'b0;
    com(1'b0);
    tick();
    tick();
    chk("rst_width", 8'(Width), 8'd16);
    chk("rst_lane", 8'(Lane_idx), 8'd0);
    chk("rst_gdone", 8'(Group_done), 8'd0);
    chk("rst_rxv", 8'(Rx_valid), 8'd0);
    chk("rst_rdy", 8'(Req_ready), 8'd0);
    chk("rst_aerr", 8'(Align_err), 8'd0);
    chk("rst_cerr", 8'(Cfg_err), 8'd0);

    Rst_n = 1'b1;
    tick();
    chk("rel_rdy", 8'(Req_ready), 8'd1);
    chk("rel_lane", 8'(Lane_idx), 8'd1);
    chk("rel_gdone", 8'(Group_done), 8'd1);
    tick();
    chk("wrap_lane", 8'(Lane_idx), 8'd0);

    com(1'b1);
    tick();
    chk("hunt_lane", 8'(Lane_idx), 8'd1);
    chk("hunt_rxv", 8'(Rx_valid), 8'd0);
    idle(3);
    com_period();
    com(1'b1);
    tick();
    chk("com3_rxv", 8'(Rx_valid), 8'd0);
    idle(3);
    com(1'b1);
    tick();
    chk("com4_rxv", 8'(Rx_valid), 8'd1);
    idle(3);

    tick();
    com(1'b1);
    tick();
    chk("mis1_aerr", 8'(Align_err), 8'd1);
    chk("mis1_rxv", 8'(Rx_valid), 8'd1);
    chk("mis1_lane", 8'(Lane_idx), 8'd0);
    idle(1);
    chk("mis1_aerr_off", 8'(Align_err), 8'd0);
    com(1'b1);
    tick();
    chk("mis2_aerr", 8'(Align_err), 8'd1);
    chk("mis2_rxv", 8'(Rx_valid), 8'd1);
    idle(1);
    com(1'b1);
    tick();
    chk("mis3_aerr", 8'(Align_err), 8'd1);
    chk("mis3_rxv", 8'(Rx_valid), 8'd0);
    chk("mis3_lane", 8'(Lane_idx), 8'd1);
    idle(1);
    chk("mis3_lane_nx", 8'(Lane_idx), 8'd0);

    com_period();
    com_period();
    com(1'b1);
    tick();
    chk("relock_rxv", 8'(Rx_valid), 8'd1);
    idle(3);

    Req_width = 6'd12;
    Req_valid = 1'b1;
    tick();
    chk("cfg_cerr", 8'(Cfg_err), 8'd1);
    chk("cfg_width", 8'(Width), 8'd16);
    chk("cfg_rxv", 8'(Rx_valid), 8'd1);
    chk("cfg_rdy", 8'(Req_ready), 8'd1);
    Req_valid = 1'b0;
    tick();
    chk("cfg_cerr_off", 8'(Cfg_err), 8'd0);

    Req_width = 6'd16;
    Req_valid = 1'b1;
    tick();
    chk("same_rdy", 8'(Req_ready), 8'd1);
    chk("same_rxv", 8'(Rx_valid), 8'd1);
    chk("same_cerr", 8'(Cfg_err), 8'd0);
    Req_valid = 1'b0;
    tick();

    Req_width = 6'd32;
    Req_valid = 1'b1;
    tick();
    chk("sw_rdy", 8'(Req_ready), 8'd0);
    chk("sw_rxv", 8'(Rx_valid), 8'd0);
    chk("sw_width", 8'(Width), 8'd16);
    chk("sw_gdone", 8'(Group_done), 8'd1);
    Req_valid = 1'b0;
    com(1'b1);
    tick();
    chk("sw_done_width", 8'(Width), 8'd32);
    chk("sw_done_lane", 8'(Lane_idx), 8'd0);
    chk("sw_done_rdy", 8'(Req_ready), 8'd1);
    chk("sw_done_rxv", 8'(Rx_valid), 8'd0);
    chk("sw_com_aerr", 8'(Align_err), 8'd0);

    com_period();
    com_period();
    com_period();
    com(1'b1);
    Req_valid = 1'b1;
    tick();
    chk("sim_noop_rxv", 8'(Rx_valid), 8'd0);
    Req_valid = 1'b0;
    idle(3);
    com(1'b1);
    tick();
    chk("w32_lock_rxv", 8'(Rx_valid), 8'd1);
    idle(3);

    Req_width = 6'd8;
    Req_valid = 1'b1;
    com(1'b1);
    tick();
    chk("sim_sw_rdy", 8'(Req_ready), 8'd0);
    chk("sim_sw_rxv", 8'(Rx_valid), 8'd0);
    chk("sim_sw_width", 8'(Width), 8'd32);
    chk("sim_sw_aerr", 8'(Align_err), 8'd0);
    Req_valid = 1'b0;
    idle(1);
    chk("mid_sw_lane", 8'(Lane_idx), 8'd2);
    #2;
    Rst_n = 1'b0;
    #1;
    chk("arst_width", 8'(Width), 8'd16);
    chk("arst_lane", 8'(Lane_idx), 8'd0);
    chk("arst_rdy", 8'(Req_ready), 8'd0);
    tick();
    chk("arst_hold_rdy", 8'(Req_ready), 8'd0);
    Rst_n = 1'b1;
    tick();
    chk("arel_rdy", 8'(Req_ready), 8'd1);
    idle(4);
    chk("arel_width", 8'(Width), 8'd16);
    chk("arel_rxv", 8'(Rx_valid), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
